sysid_verify_ctrl: RTL and testbench

- Avalon-MM read master that sequences a boot-time check of the system ID peripheral.
- Reads word 0 (system ID) and then word 1 (build timestamp) over the peripheral's control slave, and compares both against build-time expected values.
- Retries on mismatch or stall, and reports pass/fail to the reset/boot sequencer and to a status LED.
- Sits between the sysid control slave and the system boot-hold logic. The CPU is released only on pass.

---
 rtl/sysid_verify_ctrl.sv | 168 ++++++++++++++++
 tb/tb_sysid_verify_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sysid_verify_ctrl.sv
// Boot-time system ID check: reads ID and timestamp words over Avalon-MM and compares them with
// build-time constants, retrying on mismatch or stall, then reports pass/fail.
module sysid_verify_ctrl #(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1490220311,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned MAX_RETRIES    = 2,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic [3:0]  retry_count
);

  localparam int unsigned    WaitW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]     RetryMax = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    StIdle,
    StRdId,
    StRdTs,
    StCheck,
    StGap,
    StFin
  } state_e;

  state_e           r_state;
  logic [WaitW-1:0] r_wait;
  logic             r_pending;
  logic             r_att_tmo;
  logic             r_addr;
  logic             r_read;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic             r_tmo;
  logic [31:0]      r_id;
  logic [31:0]      r_ts;
  logic [3:0]       r_retry;
  logic             w_match;
  logic             w_stall_last;

  assign w_match      = (r_id == EXPECTED_ID) && (r_ts == EXPECTED_TS);
  assign w_stall_last = (r_wait == WaitLast);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state   <= StIdle;
      r_wait    <= '0;
      r_pending <= AUTO_START;
      r_att_tmo <= 1'b0;
      r_addr    <= 1'b0;
      r_read    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_tmo     <= 1'b0;
      r_id      <= '0;
      r_ts      <= '0;
      r_retry   <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start || r_pending) begin
            r_pending <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_tmo     <= 1'b0;
            r_retry   <= '0;
            r_busy    <= 1'b1;
            r_att_tmo <= 1'b0;
            r_wait    <= '0;
            r_read    <= 1'b1;
            r_addr    <= 1'b0;
            r_state   <= StRdId;
          end
        end
        StRdId: begin
          if (!avm_waitrequest) begin
            r_id    <= avm_readdata;
            r_wait  <= '0;
            r_addr  <= 1'b1;
            r_state <= StRdTs;
          end else if (w_stall_last) begin
            r_tmo     <= 1'b1;
            r_att_tmo <= 1'b1;
            r_read    <= 1'b0;
            r_wait    <= '0;
            r_state   <= StCheck;
          end else begin
            r_wait <= r_wait + WaitW'(1);
          end
        end
        StRdTs: begin
          if (!avm_waitrequest) begin
            r_ts    <= avm_readdata;
            r_wait  <= '0;
            r_read  <= 1'b0;
            r_state <= StCheck;
          end else if (w_stall_last) begin
            r_tmo     <= 1'b1;
            r_att_tmo <= 1'b1;
            r_read    <= 1'b0;
            r_wait    <= '0;
            r_state   <= StCheck;
          end else begin
            r_wait <= r_wait + WaitW'(1);
          end
        end
        StCheck: begin
          // A timed-out attempt never passes, even if stale captured words happen to match.
          if (!r_att_tmo && w_match) begin
            r_pass  <= 1'b1;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_tmo   <= 1'b0;
            r_state <= StFin;
          end else if (r_retry < RetryMax) begin
            r_retry <= r_retry + 4'd1;
            r_state <= StGap;
          end else begin
            r_pass  <= 1'b0;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_tmo   <= r_att_tmo;
            r_state <= StFin;
          end
        end
        StGap: begin
          r_att_tmo <= 1'b0;
          r_wait    <= '0;
          r_read    <= 1'b1;
          r_addr    <= 1'b0;
          r_state   <= StRdId;
        end
        StFin: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign avm_address = r_addr;
  assign avm_read    = r_read;
  assign busy        = r_busy;
  assign done        = r_done;
  assign pass        = r_pass;
  assign timeout_err = r_tmo;
  assign id_value    = r_id;
  assign ts_value    = r_ts;
  assign retry_count = r_retry;

endmodule

// File: tb/tb_sysid_verify_ctrl.sv
// Scoreboard bench for sysid_verify_ctrl: directed runs push expected results, a monitor checks
// each completed check when done rises.
module tb_sysid_verify_ctrl;

  localparam logic [31:0] TS = 32'd1490220311;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        busy;
  logic        done;
  logic        pass;
  logic        timeout_err;
  logic [31:0] id_value;
  logic [31:0] ts_value;
  logic [3:0]  retry_count;
  logic [31:0] s_id;
  logic [31:0] s_ts;

  always #5 clock = ~clock;

  assign avm_readdata = avm_address ? s_ts : s_id;

  sysid_verify_ctrl dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata   (avm_readdata),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .timeout_err    (timeout_err),
    .id_value       (id_value),
    .ts_value       (ts_value),
    .retry_count    (retry_count)
  );

  typedef struct {
    logic        pass;
    logic        tmo;
    logic [3:0]  retry;
    logic [31:0] id;
    logic [31:0] ts;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_vec = 0;
  int   n_err = 0;
  logic done_q = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic p, input logic t, input logic [3:0] r, input logic [31:0] id,
                      input logic [31:0] ts);
    exp_t x;
    x.pass = p; x.tmo = t; x.retry = r; x.id = id; x.ts = ts;
    q.push_back(x);
  endtask

  // Monitor: one scoreboard entry per rising edge of done.
  always @(negedge clock) begin
    if (done && !done_q) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 expected no completion");
      end else begin
        e = q.pop_front();
        chk("res_pass", 64'(pass), 64'(e.pass));
        chk("res_timeout_err", 64'(timeout_err), 64'(e.tmo));
        chk("res_retry_count", 64'(retry_count), 64'(e.retry));
        chk("res_id_value", 64'(id_value), 64'(e.id));
        chk("res_ts_value", 64'(ts_value), 64'(e.ts));
        chk("res_busy", 64'(busy), 64'd0);
      end
    end
    done_q <= done;
  end

  task automatic chk_reset(input string name);
    chk({name, "_status"}, 64'({avm_read, avm_address, busy, done, pass, timeout_err, retry_count}),
        64'd0);
    chk({name, "_values"}, {id_value, ts_value}, 64'd0);
  endtask

  // Counts from sample n0 until done is seen; sample 1 is the first after start is taken.
  task automatic wait_done(input string name, input int n0, input int exp_cyc);
    int n = n0;
    while (!done && n < 3000) begin
      @(negedge clock);
      n++;
    end
    chk(name, 64'(n), 64'(exp_cyc));
  endtask

  task automatic pulse_start();
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    chk("start_busy", 64'(busy), 64'd1);
    chk("start_done_clr", 64'(done), 64'd0);
  endtask

  task automatic release_and_autostart(input string name);
    @(negedge clock) reset_n = 1'b1;
    @(negedge clock);
    chk({name, "_rd_id"}, 64'({avm_read, avm_address, busy}), 64'b101);
    @(negedge clock);
    chk({name, "_rd_ts"}, 64'({avm_read, avm_address}), 64'b11);
    @(negedge clock);
    chk({name, "_check_rd_low"}, 64'(avm_read), 64'd0);
    wait_done({name, "_latency"}, 3, 4);
  endtask

  initial begin
    int hi;
    reset_n = 1'b0;
    start = 1'b0;
    avm_waitrequest = 1'b0;
    s_id = 32'd0;
    s_ts = TS;
    repeat (3) @(negedge clock);
    chk_reset("reset");

    // Auto-start with matching words.
    push(1'b0 | 1'b1, 1'b0, 4'd0, 32'd0, TS);
    release_and_autostart("auto");

    // Persistent ID mismatch; a start pulse while busy must not queue a rerun.
    s_id = 32'h0000_0001;
    push(1'b0, 1'b0, 4'd2, 32'd1, TS);
    pulse_start();
    repeat (3) @(negedge clock);
    start = 1'b1;
    @(negedge clock) start = 1'b0;
    wait_done("mismatch_latency", 5, 12);
    start = 1'b1;
    @(negedge clock) start = 1'b0;
    repeat (5) @(negedge clock);
    chk("fin_start_ignored", 64'({busy, done, retry_count}), 64'({1'b0, 1'b1, 4'd2}));

    // Permanent stall: every attempt times out.
    avm_waitrequest = 1'b1;
    s_id = 32'd0;
    push(1'b0, 1'b1, 4'd2, 32'd1, TS);
    pulse_start();
    hi = 0;
    while (avm_read && hi < 1000) begin
      hi++;
      @(negedge clock);
    end
    chk("stall_read_cycles", 64'(hi), 64'd255);
    wait_done("timeout_latency", 256, 771);
    avm_waitrequest = 1'b0;

    // First attempt mismatches, second matches.
    s_id = 32'h0000_0001;
    push(1'b1, 1'b0, 4'd1, 32'd0, TS);
    pulse_start();
    @(negedge clock);
    s_id = 32'd0;
    wait_done("retry_pass_latency", 2, 8);

    // First attempt times out, second succeeds: timeout_err must end cleared.
    avm_waitrequest = 1'b1;
    push(1'b1, 1'b0, 4'd1, 32'd0, TS);
    pulse_start();
    hi = 1;
    while (avm_read && hi < 1000) begin
      hi++;
      @(negedge clock);
    end
    avm_waitrequest = 1'b0;
    chk("tmo_mid_flag", 64'(timeout_err), 64'd1);
    wait_done("tmo_then_pass_latency", hi, 261);

    // Timestamp mismatch only.
    s_ts = TS + 32'd1;
    push(1'b0, 1'b0, 4'd2, 32'd0, TS + 32'd1);
    pulse_start();
    wait_done("ts_mismatch_latency", 1, 12);
    s_ts = TS;

    // Reset while RD_TS is stalled; auto-start re-arms.
    pulse_start();
    @(negedge clock);
    avm_waitrequest = 1'b1;
    @(negedge clock);
    chk("stalled_rd_ts", 64'({avm_read, avm_address}), 64'b11);
    reset_n = 1'b0;
    @(negedge clock);
    chk_reset("mid_reset");
    avm_waitrequest = 1'b0;
    push(1'b1, 1'b0, 4'd0, 32'd0, TS);
    release_and_autostart("rearm");

    repeat (5) @(negedge clock);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
